filter_window_dp: RTL and testbench

FILTER_WINDOW_DP -- requirements
Module: filter_window_dp

---
 rtl/filter_window_dp.sv | 99 +++++++++
 tb/tb_filter_window_dp.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/filter_window_dp.sv
// 3x3 sliding-window datapath: two line buffers feed a registered window.
// Optional window sum output enabled by FILTER_WINDOW_SUM_EN.
module filter_window_dp #(
    parameter int IMG_W = 8,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            muxcontrol1,
    input  logic [3:0]      muxout,
    input  logic [DW-1:0]   pix_in,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic            filled
`ifdef FILTER_WINDOW_SUM_EN
    ,
    output logic [DW+3:0]   win_sum
`endif
);
    localparam int FILL_MAX = 2*IMG_W + 3;
    localparam int CW       = $clog2(FILL_MAX + 1);
    localparam int PW       = $clog2(IMG_W);

    logic [DW-1:0]        lb0 [IMG_W];
    logic [DW-1:0]        lb1 [IMG_W];
    logic [8:0][DW-1:0]   win_q, win_d;
    logic [PW-1:0]        ptr, ptr_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 vld_q;
    logic                 clear, shift;

    assign clear   = en && (muxout == 4'b1111);
    assign shift   = en && (muxout != 4'b1111) && muxout[0];
    assign ptr_nxt = (ptr == PW'(IMG_W-1)) ? '0 : ptr + 1'b1;
    assign cnt_nxt = (cnt == CW'(FILL_MAX)) ? cnt : cnt + 1'b1;

    // Each row slides toward c=0; the newest column comes from the buffers.
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[r*3+0] = win_q[r*3+1];
            win_d[r*3+1] = win_q[r*3+2];
        end
        win_d[2] = lb0[ptr];
        win_d[5] = lb1[ptr];
        win_d[8] = pix_in;
    end

    // Line buffers carry no reset so they map onto RAM.
    always_ff @(posedge clk) begin
        if (shift) begin
            lb1[ptr] <= pix_in;
            lb0[ptr] <= lb1[ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
            vld_q <= 1'b0;
        end else if (clear) begin
            win_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
            vld_q <= 1'b0;
        end else if (shift) begin
            win_q <= win_d;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            vld_q <= muxout[2] && muxcontrol1 && (cnt_nxt == CW'(FILL_MAX));
        end else begin
            vld_q <= 1'b0;
        end
    end

    assign win       = win_q;
    assign win_valid = vld_q;
    assign filled    = (cnt == CW'(FILL_MAX));

`ifdef FILTER_WINDOW_SUM_EN
    logic [DW+3:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++)
            sum_d = sum_d + (DW+4)'(win_d[i]);
    end

    // Tracks the window register so it lines up with win_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        win_sum <= '0;
        else if (clear) win_sum <= '0;
        else if (shift) win_sum <= sum_d;
    end
`endif
endmodule

// File: tb/tb_filter_window_dp.sv
// Directed bench for filter_window_dp (IMG_W=8, DW=8); pixel value j is the j-th
// pixel after CLEAR, so expected windows follow from k alone.
module tb_filter_window_dp;
    localparam int IMG_W = 8;
    localparam int DW    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            muxcontrol1 = 1'b0;
    logic [3:0]      muxout = 4'b0000;
    logic [DW-1:0]   pix_in = '0;
    logic [9*DW-1:0] win;
    logic            win_valid;
    logic            filled;
`ifdef FILTER_WINDOW_SUM_EN
    logic [DW+3:0]   win_sum;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    filter_window_dp #(.IMG_W(IMG_W), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .muxcontrol1(muxcontrol1),
        .muxout     (muxout),
        .pix_in     (pix_in),
        .win        (win),
        .win_valid  (win_valid),
        .filled     (filled)
`ifdef FILTER_WINDOW_SUM_EN
        ,
        .win_sum    (win_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Window after the k-th SHIFT since CLEAR: rows hold pixels k-18.., k-10.., k-2..
    function automatic logic [9*DW-1:0] exp_win(input int k);
        logic [9*DW-1:0] w;
        int base [3];
        base[0] = k - 18;
        base[1] = k - 10;
        base[2] = k - 2;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*DW +: DW] = DW'(base[r] + c);
        return w;
    endfunction

    task automatic step(input logic e, input logic [3:0] m, input logic mc, input int p);
        en = e; muxout = m; muxcontrol1 = mc; pix_in = DW'(p);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 1'b0, 0);
    endtask

    logic [9*DW-1:0] held;

    initial begin
        #12;
        chk("rst_win", win, 0);
        chk("rst_valid", win_valid, 0);
        chk("rst_filled", filled, 0);
        @(negedge clk); rst = 1'b0;
        idle();

        // Prime and stream with output enabled.
        step(1'b1, 4'b1111, 1'b0, 0);
        for (int k = 1; k <= 19; k++) begin
            step(1'b1, 4'b0101, 1'b1, k);
            chk($sformatf("s1_valid_k%0d", k), win_valid, (k == 19));
        end
        chk("s1_win", win, 72'h11_12_13_09_0A_0B_01_02_03 == 0 ? 0 : {8'd19,8'd18,8'd17,8'd11,8'd10,8'd9,8'd3,8'd2,8'd1});
        chk("s1_filled", filled, 1);
`ifdef FILTER_WINDOW_SUM_EN
        chk("s1_sum", win_sum, 90);
`endif

        // Hold: en=0 then NOP code.
        held = win;
        step(1'b0, 4'b0101, 1'b1, 99);
        chk("en0_win", win, held);
        chk("en0_valid", win_valid, 0);
        chk("en0_filled", filled, 1);
        step(1'b1, 4'b0000, 1'b1, 98);
        chk("nop_win", win, held);
        chk("nop_valid", win_valid, 0);
        step(1'b1, 4'b0101, 1'b1, 20);
        chk("k20_win", win, exp_win(20));
        chk("k20_valid", win_valid, 1);

        // Compute-phase gating.
        step(1'b1, 4'b0101, 1'b0, 21);
        chk("mc0_win", win, exp_win(21));
        chk("mc0_valid", win_valid, 0);
        step(1'b1, 4'b0101, 1'b1, 22);
        chk("mc1_win", win, exp_win(22));
        chk("mc1_valid", win_valid, 1);
`ifdef FILTER_WINDOW_SUM_EN
        chk("k22_sum", win_sum, 9*22 - 81);
`endif

        // Asynchronous reset mid-stream, mid-cycle.
        en = 1'b1; muxout = 4'b0101; muxcontrol1 = 1'b1; pix_in = 8'd23;
        #2 rst = 1'b1;
        #1;
        chk("arst_win", win, 0);
        chk("arst_valid", win_valid, 0);
        chk("arst_filled", filled, 0);
        @(negedge clk); rst = 1'b0;
        step(1'b1, 4'b0000, 1'b1, 5);
        step(1'b0, 4'b0101, 1'b1, 6);
        chk("post_rst_win", win, 0);
        chk("post_rst_filled", filled, 0);

        // Prime only: filled rises, win_valid never.
        step(1'b1, 4'b1111, 1'b0, 0);
        for (int k = 1; k <= 19; k++) begin
            step(1'b1, 4'b0001, 1'b1, k);
            chk($sformatf("s2_valid_k%0d", k), win_valid, 0);
            if (k >= 18) chk($sformatf("s2_filled_k%0d", k), filled, (k == 19));
        end
        chk("s2_win", win, exp_win(19));

        // 40 pixels across five line boundaries, then CLEAR.
        step(1'b1, 4'b1111, 1'b0, 0);
        chk("clr_win", win, 0);
        chk("clr_filled", filled, 0);
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 4'b0101, 1'b1, k);
            chk($sformatf("s3_valid_k%0d", k), win_valid, (k >= 19));
            if (k >= 19) chk($sformatf("s3_win_k%0d", k), win, exp_win(k));
        end
        step(1'b1, 4'b1111, 1'b1, 0);
        chk("end_clr_win", win, 0);
        chk("end_clr_filled", filled, 0);
        chk("end_clr_valid", win_valid, 0);
`ifdef FILTER_WINDOW_SUM_EN
        chk("end_clr_sum", win_sum, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
